// File: rtl/video_src_switch_ctrl.sv
// rtl/video_src_switch_ctrl.sv - frame-aligned source select, geometry check and stall watchdog for the pattern stage
module video_src_switch_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int TIMEOUT  = 1048576,
  parameter int FCNT_W   = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_sel_req,
  input  logic              i_fallback_en,
  input  logic              i_err_clr,
  input  logic              i_vid_tvalid,
  input  logic              i_vid_tready,
  input  logic              i_vid_tuser,
  input  logic              i_vid_tlast,
  output logic              o_sel_stat,
  output logic              o_switch_pending,
  output logic              o_src_lost,
  output logic              o_in_frame,
  output logic [FCNT_W-1:0] o_frame_cnt,
  output logic              o_line_err,
  output logic              o_sof_err
);

  localparam int PW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int LW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [PW-1:0] PIX_LAST  = PW'(H_ACTIVE - 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(V_ACTIVE - 1);
  localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_LOST  = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_sel_stat;
  logic              r_switch_pending;
  logic              r_src_lost;
  logic              r_in_frame;
  logic [FCNT_W-1:0] r_frame_cnt;
  logic              r_line_err;
  logic              r_sof_err;
  logic [PW-1:0]     r_pix_cnt;
  logic [LW-1:0]     r_line_cnt;
  logic [WW-1:0]     r_wd_cnt;

  logic          w_beat;
  logic          w_sof;
  logic          w_eol;
  logic          w_expire;
  logic [PW-1:0] w_pix_idx;
  logic [LW-1:0] w_line_idx;
  logic          w_frame_end;
  logic          w_line_err_set;
  logic          w_sof_err_set;
  logic          w_forced_sel;

  // A SOF beat is pixel 0 of line 0, so the EOL check of a SOF+EOL beat sees position 0.
  assign w_beat      = i_vid_tvalid & i_vid_tready;
  assign w_sof       = w_beat & i_vid_tuser;
  assign w_eol       = w_beat & i_vid_tlast;
  assign w_expire    = ~w_beat & (r_wd_cnt == WD_LAST);
  assign w_pix_idx   = i_vid_tuser ? '0 : r_pix_cnt;
  assign w_line_idx  = i_vid_tuser ? '0 : r_line_cnt;
  assign w_frame_end = w_eol & (w_line_idx == LINE_LAST);
  assign w_forced_sel = i_fallback_en | r_sel_stat;

  assign w_line_err_set = w_beat & (i_vid_tlast ? (w_pix_idx != PIX_LAST) : (w_pix_idx == PIX_LAST));
  assign w_sof_err_set  = w_beat & (i_vid_tuser ? r_in_frame : ~r_in_frame);

  // Pending flag compares the request with the selection that will be in force after this edge.
  function automatic logic f_pend(input logic req, input logic fb, input logic sel_nxt, input logic lost_nxt);
    return req != ((lost_nxt & fb) | sel_nxt);
  endfunction

  // Idle-cycle watchdog: cleared by any accepted beat, saturates at the expiry value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wd_cnt <= '0;
    end else if (w_beat) begin
      r_wd_cnt <= '0;
    end else if (r_wd_cnt != WD_LAST) begin
      r_wd_cnt <= r_wd_cnt + WW'(1);
    end
  end

  // Pixel/line position and frame counter; a watchdog expiry discards the partial frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pix_cnt   <= '0;
      r_line_cnt  <= '0;
      r_frame_cnt <= '0;
    end else if (w_expire) begin
      r_pix_cnt  <= '0;
      r_line_cnt <= '0;
    end else if (w_beat) begin
      r_frame_cnt <= r_frame_cnt + FCNT_W'(i_vid_tuser);
      if (i_vid_tlast) begin
        r_pix_cnt  <= '0;
        r_line_cnt <= (w_line_idx == LINE_LAST) ? '0 : w_line_idx + LW'(1);
      end else begin
        r_pix_cnt  <= (w_pix_idx == PIX_LAST) ? '0 : w_pix_idx + PW'(1);
        r_line_cnt <= w_line_idx;
      end
    end
  end

  // Sticky geometry errors; a new error in the clear cycle keeps the flag set.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_line_err <= 1'b0;
      r_sof_err  <= 1'b0;
    end else begin
      r_line_err <= w_line_err_set | (r_line_err & ~i_err_clr);
      r_sof_err  <= w_sof_err_set  | (r_sof_err  & ~i_err_clr);
    end
  end

  // Source-select FSM: selection only moves outside a frame or at its last beat.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state          <= ST_IDLE;
      r_sel_stat       <= 1'b0;
      r_switch_pending <= 1'b0;
      r_src_lost       <= 1'b0;
      r_in_frame       <= 1'b0;
    end else if (w_expire) begin
      r_state          <= ST_LOST;
      r_src_lost       <= 1'b1;
      r_in_frame       <= 1'b0;
      r_sel_stat       <= w_forced_sel;
      r_switch_pending <= f_pend(i_sel_req, i_fallback_en, w_forced_sel, 1'b1);
    end else if (w_frame_end && (w_sof || r_state == ST_FRAME)) begin
      r_state          <= ST_IDLE;
      r_src_lost       <= 1'b0;
      r_in_frame       <= 1'b0;
      r_sel_stat       <= i_sel_req;
      r_switch_pending <= 1'b0;
    end else if (w_sof) begin
      r_state          <= ST_FRAME;
      r_src_lost       <= 1'b0;
      r_in_frame       <= 1'b1;
      r_switch_pending <= f_pend(i_sel_req, i_fallback_en, r_sel_stat, 1'b0);
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_sel_stat       <= i_sel_req;
          r_switch_pending <= 1'b0;
        end
        ST_FRAME: begin
          r_switch_pending <= f_pend(i_sel_req, i_fallback_en, r_sel_stat, 1'b0);
        end
        ST_LOST: begin
          r_sel_stat       <= w_forced_sel;
          r_switch_pending <= f_pend(i_sel_req, i_fallback_en, w_forced_sel, 1'b1);
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_sel_stat       = r_sel_stat;
  assign o_switch_pending = r_switch_pending;
  assign o_src_lost       = r_src_lost;
  assign o_in_frame       = r_in_frame;
  assign o_frame_cnt      = r_frame_cnt;
  assign o_line_err       = r_line_err;
  assign o_sof_err        = r_sof_err;

endmodule

// File: tb/tb_video_src_switch_ctrl.sv
// tb/tb_video_src_switch_ctrl.sv - directed vector bench for video_src_switch_ctrl
module tb_video_src_switch_ctrl;

  localparam int H  = 4;
  localparam int V  = 3;
  localparam int TO = 16;
  localparam int FW = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          sel_req = 1'b0;
  logic          fallback_en = 1'b0;
  logic          err_clr = 1'b0;
  logic          tvalid = 1'b0;
  logic          tready = 1'b0;
  logic          tuser = 1'b0;
  logic          tlast = 1'b0;
  logic          sel_stat;
  logic          switch_pending;
  logic          src_lost;
  logic          in_frame;
  logic [FW-1:0] frame_cnt;
  logic          line_err;
  logic          sof_err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic tv;
    logic tu;
    logic tl;
    logic sr;
    logic e_sel;
    logic e_pend;
    logic e_inf;
    int   e_fcnt;
  } vec_t;

  vec_t vecs[$];

  video_src_switch_ctrl #(
    .H_ACTIVE(H), .V_ACTIVE(V), .TIMEOUT(TO), .FCNT_W(FW)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .i_sel_req(sel_req),
    .i_fallback_en(fallback_en),
    .i_err_clr(err_clr),
    .i_vid_tvalid(tvalid),
    .i_vid_tready(tready),
    .i_vid_tuser(tuser),
    .i_vid_tlast(tlast),
    .o_sel_stat(sel_stat),
    .o_switch_pending(switch_pending),
    .o_src_lost(src_lost),
    .o_in_frame(in_frame),
    .o_frame_cnt(frame_cnt),
    .o_line_err(line_err),
    .o_sof_err(sof_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int e_sel, input int e_pend, input int e_lost,
                         input int e_inf, input int e_fcnt, input int e_lerr, input int e_serr);
    chk({tag, ".sel_stat"},       int'(sel_stat),       e_sel);
    chk({tag, ".switch_pending"}, int'(switch_pending), e_pend);
    chk({tag, ".src_lost"},       int'(src_lost),       e_lost);
    chk({tag, ".in_frame"},       int'(in_frame),       e_inf);
    chk({tag, ".frame_cnt"},      int'(frame_cnt),      e_fcnt);
    chk({tag, ".line_err"},       int'(line_err),       e_lerr);
    chk({tag, ".sof_err"},        int'(sof_err),        e_serr);
  endtask

  task automatic cyc(input logic tv, input logic tr, input logic tu, input logic tl);
    tvalid = tv;
    tready = tr;
    tuser  = tu;
    tlast  = tl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // frames 1-2: clean stream with sel_req=0; frames 3-4: sel_req rises at beat 5 of frame 3
    for (int f = 0; f < 4; f++) begin
      for (int j = 0; j < 12; j++) begin
        vec_t v;
        v.tv     = 1'b1;
        v.tu     = (j == 0);
        v.tl     = ((j % 4) == 3);
        v.sr     = (f == 2 && j >= 5) || (f == 3);
        v.e_sel  = (f == 2 && j == 11) || (f == 3);
        v.e_pend = (f == 2 && j >= 5 && j <= 10);
        v.e_inf  = (j != 11);
        v.e_fcnt = f + 1;
        vecs.push_back(v);
      end
    end

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 0, 0, 0, 0, 0, 0, 0);
    rstn = 1'b1;

    // table-driven clean stream and mid-frame switch
    for (int i = 0; i < vecs.size(); i++) begin
      sel_req = vecs[i].sr;
      cyc(vecs[i].tv, 1'b1, vecs[i].tu, vecs[i].tl);
      chk_out($sformatf("vec%0d", i), vecs[i].e_sel, vecs[i].e_pend, 0,
              vecs[i].e_inf, vecs[i].e_fcnt, 0, 0);
    end

    // back to camera between frames
    sel_req = 1'b0;
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("idle_resel.sel_stat", int'(sel_stat), 0);

    // geometry error: tlast on the 3rd pixel of the first line
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk("geo_stall.line_err", int'(line_err), 0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    chk("geo_short.line_err", int'(line_err), 1);
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0, (i % 4) == 3);
    chk_out("geo_end", 0, 0, 0, 0, 5, 1, 0);
    err_clr = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    err_clr = 1'b0;
    chk("geo_clr.line_err", int'(line_err), 0);

    // misplaced SOF at pixel 2 restarts the frame
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk_out("msof", 0, 0, 0, 1, 7, 0, 1);
    for (int j = 1; j < 12; j++) begin
      cyc(1'b1, 1'b1, 1'b0, (j % 4) == 3);
      if (j == 10) chk("msof_pre_end.in_frame", int'(in_frame), 1);
    end
    chk_out("msof_end", 0, 0, 0, 0, 7, 0, 1);
    err_clr = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    err_clr = 1'b0;
    chk("msof_clr.sof_err", int'(sof_err), 0);

    // watchdog with fallback: stall mid-frame
    fallback_en = 1'b1;
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < TO - 1; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk_out("wd_before", 0, 0, 0, 1, 8, 0, 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk_out("wd_lost", 1, 1, 1, 0, 8, 0, 0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk_out("wd_resume", 1, 1, 0, 1, 9, 0, 0);
    for (int j = 1; j < 12; j++) begin
      cyc(1'b1, 1'b1, 1'b0, (j % 4) == 3);
      if (j == 10) chk("wd_frame.sel_stat", int'(sel_stat), 1);
    end
    chk_out("wd_end", 0, 0, 0, 0, 9, 0, 0);
    fallback_en = 1'b0;

    // beat on the expiry cycle keeps the source alive
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < TO - 1; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("race_pre.src_lost", int'(src_lost), 0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk_out("race", 0, 0, 0, 1, 10, 0, 0);

    // asynchronous reset mid-frame
    #2;
    rstn = 1'b0;
    #1;
    chk_out("areset", 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk_out("post_reset_beat", 0, 0, 0, 0, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/video_src_switch_ctrl.md
Name: video_src_switch_ctrl

Overview:
- Controller for the synthetic-picture / camera-pass-through stage in the video pipeline.
- Snoops the AXI4-Stream video handshake and drives the stage's source-select input (`sel_stat`).
- Applies software select requests only at frame boundaries, so no frame is ever mixed.
- Also checks frame geometry, counts frames, and runs a stall watchdog that can force the synthetic source.

Parameters:
- H_ACTIVE, 640, pixels (accepted beats) per line.
- V_ACTIVE, 480, lines per frame.
- TIMEOUT, 1048576, idle cycles without an accepted beat before `src_lost` asserts (≥2).
- FCNT_W, 16, width of the frame counter.

Ports:
- clk  in  1  video clock.
- rstn  in  1  reset, asynchronous, active-low.
- sel_req  in  1  requested source: 1 = synthetic, 0 = camera. Quasi-static, synchronous to clk.
- fallback_en  in  1  1 = force synthetic while the source is lost.
- err_clr  in  1  single-cycle pulse; clears the sticky errors.
- vid_tvalid  in  1  snooped stream tvalid.
- vid_tready  in  1  snooped stream tready.
- vid_tuser  in  1  snooped start of frame (SOF).
- vid_tlast  in  1  snooped end of line (EOL).
- sel_stat  out  1  registered source select to the pattern stage.
- switch_pending  out  1  `sel_req` differs from the applied selection.
- src_lost  out  1  watchdog expired.
- in_frame  out  1  a frame is in progress.
- frame_cnt  out  FCNT_W  accepted SOF beats, wraps modulo 2^FCNT_W.
- line_err  out  1  sticky EOL position error.
- sof_err  out  1  sticky misplaced SOF or missing SOF.

Behaviour:
- Reset values of all outputs are 0, and the applied selection is 0 (camera). Internal counters reset to 0.
- Beat definition: beat = vid_tvalid & vid_tready. Nothing changes on non-accepted cycles except the watchdog.
- Position counters `pix_cnt` (0..H_ACTIVE-1) and `line_cnt` (0..V_ACTIVE-1):
  - A beat with tuser sets pix_cnt=1, line_cnt=0 and in_frame=1, and increments frame_cnt.
  - Any other beat increments pix_cnt.
  - A beat with tlast sets pix_cnt=0 and increments line_cnt.
  - A tuser+tlast beat (only legal when H_ACTIVE=1) behaves as SOF followed by EOL.
- Frame end is a tlast beat with line_cnt==V_ACTIVE-1. On frame end: in_frame=0 and line_cnt=0.
- line_err is set on a tlast beat whose pixel index (pix_cnt before the beat) ≠ H_ACTIVE-1. It is also set when pix_cnt would pass H_ACTIVE-1 without tlast; in that case pix_cnt wraps to 0.
- sof_err is set on:
  - a tuser beat while in_frame=1 (counters restart as a normal SOF), or
  - a non-tuser beat while in_frame=0 (counters advance, in_frame stays 0).
- Sticky errors clear on err_clr. If err_clr coincides with a new error, the set wins.
- State machine, registered, one transition per cycle:
  - IDLE (in_frame=0):
    - sel_stat follows sel_req: the update is registered the cycle after sel_req changes.
    - On a tuser beat → FRAME.
    - sel_stat is never changed in the same cycle as a tuser beat. The value present on the SOF beat governs the whole frame.
  - FRAME:
    - sel_stat is frozen.
    - On the frame-end beat, sel_stat ← sel_req in that same edge → IDLE. The new value therefore holds from the first beat after the frame end.
    - On a misplaced SOF → stay in FRAME, sel_stat unchanged.
  - LOST: entered from any state when the watchdog expires.
    - If fallback_en=1, sel_stat←1; otherwise sel_stat is held.
    - in_frame←0 and counters reset.
    - On a tuser beat → FRAME, with src_lost←0. sel_stat keeps its LOST value for that frame and re-evaluates at its frame end.
    - A non-tuser beat in LOST sets sof_err and stays in LOST.
- switch_pending = (sel_req ≠ applied target), registered. The applied target is the LOST-forced value while src_lost & fallback_en.
- Watchdog:
  - The counter resets to 0 on every beat and otherwise increments, saturating.
  - When it reaches TIMEOUT-1 without a beat, src_lost asserts on the next edge.
  - A beat in the same cycle as expiry wins: no src_lost.
- Asynchronous reset mid-frame returns everything to reset values. The first post-reset beat without tuser sets sof_err.
- frame_cnt wraps from 2^FCNT_W-1 to 0 without error.

Test Plan (H_ACTIVE=4, V_ACTIVE=3, TIMEOUT=16):
- Clean stream, sel_req=0:
  - Stimulus: 2 frames of 12 beats, tuser on beats 0/12, tlast every 4th.
  - Required: frame_cnt=2, line_err=sof_err=0, in_frame=0 after beat 24, sel_stat=0 throughout.
- Mid-frame switch:
  - Stimulus: raise sel_req=1 at beat 5 of frame 1.
  - Required: sel_stat stays 0 through beat 11, becomes 1 the edge of beat 11 (frame end), and is 1 on frame 2's SOF. switch_pending=1 from beat 6 to the frame end.
- Geometry error:
  - Stimulus: tlast on the 3rd pixel of line 1.
  - Required: line_err=1 and held. err_clr pulse → 0.
- Misplaced SOF:
  - Stimulus: tuser at pixel 2 of line 1.
  - Required: sof_err=1, frame_cnt+1, counters restart (a frame end is needed 12 beats later).
- Watchdog with fallback_en=1, sel_req=0:
  - Stimulus: stop tvalid mid-frame for 16 cycles.
  - Required: src_lost=1, sel_stat=1. Resume with a SOF → src_lost=0, sel_stat=1 for that frame, 0 after its frame end.
- Watchdog race and reset:
  - Stimulus: a beat exactly on the expiry cycle.
  - Required: no src_lost.
  - Stimulus: rstn pulse mid-frame.
  - Required: all outputs 0. A next non-tuser beat sets sof_err.
